alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, data path width of operands and result.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: cmd_valid  input  1  command present.
REQ-005 Port: cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-006 Port: cmd_op  input  5  ALU opcode, 5'b00001..5'b10000 legal.
REQ-007 Port: cmd_a, cmd_b  input  WIDTH  operands.
REQ-008 Port: cmd_cin  input  1  carry/borrow in.
REQ-009 Port: cmd_use_acc  input  1  substitute accumulator for cmd_a.
REQ-010 Port: alu_A, alu_B  output  WIDTH  operands driven to the ALU.
REQ-011 Port: alu_Cin  output  1; alu_Card  output  5  opcode driven to the ALU.
REQ-012 Port: alu_F  input  WIDTH; alu_Cout  input  1; alu_Zero  input  1  ALU results.
REQ-013 Port: rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-014 Port: rsp_f  output  WIDTH; rsp_cout, rsp_zero, rsp_err  output  1 each.
REQ-015 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, DRIVE, RESP; cmd_ready SHALL equal (state==IDLE).
REQ-017 IDLE->DRIVE on cmd_valid&&cmd_ready: alu_A (acc if cmd_use_acc else cmd_a), alu_B, alu_Cin, alu_Card registered at that edge.
REQ-018 DRIVE->RESP unconditionally after one cycle; at that edge rsp_f, rsp_cout, rsp_zero, rsp_err registered.
REQ-019 rsp_valid SHALL assert exactly 2 edges after the accepting edge and hold until rsp_valid&&rsp_ready.
REQ-020 RESP->IDLE on rsp_ready; rsp_* and alu_* outputs SHALL remain stable while rsp_valid is high and rsp_ready low.
REQ-021 rsp_cout SHALL be alu_Cout for opcodes 00001/00010, else 0.
REQ-022 Illegal opcode (00000, 10001..11111): rsp_err=1, rsp_f=all ones, rsp_cout=0, rsp_zero=0, accumulator unchanged.
REQ-023 Legal opcode: rsp_err=0, rsp_f=alu_F, rsp_zero=alu_Zero, accumulator<=alu_F at the DRIVE->RESP edge.
REQ-024 Throughput: at most one command per 3 cycles; no command accepted outside IDLE.
REQ-025 Accumulator width WIDTH, wraps naturally; never updated outside the DRIVE->RESP edge.

Reset
REQ-026 rst high SHALL immediately force state IDLE, accumulator 0, alu_* 0, rsp_* 0, rsp_valid 0, busy 0, cmd_ready 1 after deassertion.
REQ-027 Reset in DRIVE or RESP SHALL abandon the command with no response; first edge after deassertion may accept a new command.

Structure
REQ-028 Shared package alu_pkg SHALL hold the 16 opcode constants, WIDTH default, and FSM state encoding.
REQ-029 Opcode legality check SHALL be a function in alu_pkg; no sub-module; ALU instanced by the parent.

Verification
REQ-030 add 00001, A=5, B=7 -> rsp_f=12, rsp_cout=0, rsp_zero=0, rsp_valid 2 edges after accept.
REQ-031 add_Cin 00010, A=32'hFFFFFFFF, B=0, Cin=1 -> rsp_f=0, rsp_cout=1, rsp_zero=1.
REQ-032 Chain: equal_A 00111 A=3, then add 00001 cmd_use_acc=1 B=4 -> second rsp_f=7.
REQ-033 Op 10001 -> rsp_err=1, rsp_f=32'hFFFFFFFF; following use_acc command sees prior acc.
REQ-034 rsp_ready low 5 cycles in RESP -> rsp_* stable, cmd_ready 0, busy 1; accept on release.
REQ-035 rst pulse during DRIVE -> no response, outputs 0 asynchronously, next command completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcode map, default width,
// sequencer state encoding and the opcode legality check.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [4:0] OP_ADD        = 5'b00001;
    localparam logic [4:0] OP_ADD_CIN    = 5'b00010;
    localparam logic [4:0] OP_SUB        = 5'b00011;
    localparam logic [4:0] OP_SUB_BORROW = 5'b00100;
    localparam logic [4:0] OP_INC_A      = 5'b00101;
    localparam logic [4:0] OP_DEC_A      = 5'b00110;
    localparam logic [4:0] OP_EQUAL_A    = 5'b00111;
    localparam logic [4:0] OP_EQUAL_B    = 5'b01000;
    localparam logic [4:0] OP_AND        = 5'b01001;
    localparam logic [4:0] OP_OR         = 5'b01010;
    localparam logic [4:0] OP_XOR        = 5'b01011;
    localparam logic [4:0] OP_NOT_A      = 5'b01100;
    localparam logic [4:0] OP_SHL        = 5'b01101;
    localparam logic [4:0] OP_SHR        = 5'b01110;
    localparam logic [4:0] OP_NAND       = 5'b01111;
    localparam logic [4:0] OP_NOR        = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_e;

    function automatic logic op_is_legal(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_NOR);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Accepts one ALU command, drives it to an external ALU for one cycle, captures
// the result and holds it until the response is taken; keeps a result accumulator.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic             alu_Cin,
    output logic [4:0]       alu_Card,
    input  logic [WIDTH-1:0] alu_F,
    input  logic             alu_Cout,
    input  logic             alu_Zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_f,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             alu_cin_q, alu_cin_d;
    logic [4:0]       alu_card_q, alu_card_d;
    logic [WIDTH-1:0] rsp_f_q, rsp_f_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;
    logic             op_legal;
    logic             op_has_carry;

    assign op_legal     = op_is_legal(alu_card_q);
    assign op_has_carry = (alu_card_q == OP_ADD) || (alu_card_q == OP_ADD_CIN);

    // NOTE: every next-state signal is defaulted to its current value first so no
    // path through the case leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cin_d  = alu_cin_q;
        alu_card_d = alu_card_q;
        rsp_f_d    = rsp_f_q;
        rsp_cout_d = rsp_cout_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    alu_a_d    = cmd_use_acc ? acc_q : cmd_a;
                    alu_b_d    = cmd_b;
                    alu_cin_d  = cmd_cin;
                    alu_card_d = cmd_op;
                    state_d    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // Illegal opcodes report a fixed error pattern and leave the accumulator alone.
                if (op_legal) begin
                    rsp_f_d    = alu_F;
                    rsp_cout_d = op_has_carry ? alu_Cout : 1'b0;
                    rsp_zero_d = alu_Zero;
                    rsp_err_d  = 1'b0;
                    acc_d      = alu_F;
                end else begin
                    rsp_f_d    = '1;
                    rsp_cout_d = 1'b0;
                    rsp_zero_d = 1'b0;
                    rsp_err_d  = 1'b1;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update
    // together from values sampled before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cin_q  <= 1'b0;
            alu_card_q <= '0;
            rsp_f_q    <= '0;
            rsp_cout_q <= 1'b0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            alu_card_q <= alu_card_d;
            rsp_f_q    <= rsp_f_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign alu_A     = alu_a_q;
    assign alu_B     = alu_b_q;
    assign alu_Cin   = alu_cin_q;
    assign alu_Card  = alu_card_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU attached to
// the alu_* ports; expected values are hand-computed constants.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [4:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_cin;
    logic         cmd_use_acc;
    logic [W-1:0] alu_A;
    logic [W-1:0] alu_B;
    logic         alu_Cin;
    logic [4:0]   alu_Card;
    logic [W-1:0] alu_F;
    logic         alu_Cout;
    logic         alu_Zero;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_f;
    logic         rsp_cout;
    logic         rsp_zero;
    logic         rsp_err;
    logic         busy;

    int checks;
    int errors;

    alu_cmd_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_cin    (cmd_cin),
        .cmd_use_acc(cmd_use_acc),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_Cin    (alu_Cin),
        .alu_Card   (alu_Card),
        .alu_F      (alu_F),
        .alu_Cout   (alu_Cout),
        .alu_Zero   (alu_Zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_f      (rsp_f),
        .rsp_cout   (rsp_cout),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; unknown opcodes return zero with carry set so that any
    // leakage into an error response is visible.
    logic [W:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        case (alu_Card)
            OP_ADD:     alu_sum = {1'b0, alu_A} + {1'b0, alu_B};
            OP_ADD_CIN: alu_sum = {1'b0, alu_A} + {1'b0, alu_B} + {{W{1'b0}}, alu_Cin};
            OP_EQUAL_A: alu_sum = {1'b0, alu_A};
            default:    alu_sum = {1'b1, {W{1'b0}}};
        endcase
    end
    assign alu_F    = alu_sum[W-1:0];
    assign alu_Cout = alu_sum[W];
    assign alu_Zero = (alu_sum[W-1:0] == '0);

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one cycle and follows it to the RESP state,
    // checking handshake timing and the operands driven to the ALU.
    task automatic send(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin, input logic use_acc,
                        input logic [W-1:0] exp_alu_a);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_cin     = cin;
        cmd_use_acc = use_acc;
        check({tag, ".cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        check({tag, ".drive_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, ".drive_busy"}, {31'd0, busy}, 32'd1);
        check({tag, ".alu_A"}, alu_A, exp_alu_a);
        check({tag, ".alu_Card"}, {27'd0, alu_Card}, {27'd0, op});
        tick();
        check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic take(input string tag, input logic [W-1:0] exp_f, input logic exp_cout,
                        input logic exp_zero, input logic exp_err);
        check({tag, ".rsp_f"}, rsp_f, exp_f);
        check({tag, ".rsp_cout"}, {31'd0, rsp_cout}, {31'd0, exp_cout});
        check({tag, ".rsp_zero"}, {31'd0, rsp_zero}, {31'd0, exp_zero});
        check({tag, ".rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, ".done_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, ".done_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_cin     = 1'b0;
        cmd_use_acc = 1'b0;
        rsp_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst.alu_A", alu_A, 32'd0);
        check("rst.rsp_f", rsp_f, 32'd0);
        rst = 1'b0;
        tick();

        // Plain add
        send("add", OP_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 32'd5);
        take("add", 32'd12, 1'b0, 1'b0, 1'b0);

        // Add with carry-in wrapping to zero
        send("addc", OP_ADD_CIN, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        take("addc", 32'd0, 1'b1, 1'b1, 1'b0);

        // Accumulator chain: acc=3 then acc+4
        send("eqa", OP_EQUAL_A, 32'd3, 32'd0, 1'b0, 1'b0, 32'd3);
        take("eqa", 32'd3, 1'b0, 1'b0, 1'b0);
        send("chain", OP_ADD, 32'd100, 32'd4, 1'b0, 1'b1, 32'd3);
        take("chain", 32'd7, 1'b0, 1'b0, 1'b0);

        // Illegal opcode leaves the accumulator at 7
        send("illegal", 5'b10001, 32'd9, 32'd0, 1'b0, 1'b0, 32'd9);
        take("illegal", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        send("post_illegal", OP_ADD, 32'd0, 32'd1, 1'b0, 1'b1, 32'd7);
        take("post_illegal", 32'd8, 1'b0, 1'b0, 1'b0);

        // Back-pressure: response held for 5 cycles while a new command waits
        send("stall", OP_ADD, 32'd1, 32'd1, 1'b0, 1'b0, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_a     = 32'd50;
        cmd_b     = 32'd50;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall.rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall.rsp_f", rsp_f, 32'd2);
            check("stall.cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("stall.busy", {31'd0, busy}, 32'd1);
            check("stall.alu_A", alu_A, 32'd1);
        end
        cmd_valid = 1'b0;
        take("stall", 32'd2, 1'b0, 1'b0, 1'b0);
        send("release", OP_ADD, 32'd10, 32'd20, 1'b0, 1'b0, 32'd10);
        take("release", 32'd30, 1'b0, 1'b0, 1'b0);

        // Reset pulse during DRIVE abandons the command
        cmd_valid   = 1'b1;
        cmd_op      = OP_ADD;
        cmd_a       = 32'd40;
        cmd_b       = 32'd2;
        cmd_use_acc = 1'b0;
        tick();
        cmd_valid = 1'b0;
        check("abort.in_drive", {31'd0, busy}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort.alu_A", alu_A, 32'd0);
        check("abort.rsp_f", rsp_f, 32'd0);
        check("abort.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        tick();
        check("abort.no_rsp", {31'd0, rsp_valid}, 32'd0);

        // Accumulator was cleared by the reset
        send("after_rst", OP_ADD, 32'd0, 32'd6, 1'b0, 1'b1, 32'd0);
        take("after_rst", 32'd6, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
